axis_seq_checker: RTL

AXIS_SEQ_CHECKER -- requirements
Module: axis_seq_checker

---
 rtl/axis_tb_pkg.sv | 15 +
 rtl/lfsr16.sv | 32 +++
 rtl/axis_seq_checker.sv | 115 +++++++++++
 3 files changed

// File: rtl/axis_tb_pkg.sv
// Shared definitions for the AXI-Stream sequence checker: FSM encoding and
// throttle LFSR constants.
package axis_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Fibonacci taps x^16 + x^14 + x^13 + x^11 -> state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reload; advances only when enabled.
import axis_tb_pkg::*;

module lfsr16 #(
  parameter logic [15:0] RESET_VAL = LFSR_DEFAULT_SEED,
  parameter int unsigned Q_BITS    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [15:0]       seed,
  input  logic              en,
  output logic [Q_BITS-1:0] q
);

  logic [15:0] state;
  logic        fb;

  assign fb = ^(state & LFSR_TAPS);
  assign q  = state[Q_BITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_VAL;
    end else if (load) begin
      state <= seed;
    end else if (en) begin
      state <= {state[14:0], fb};
    end
  end

endmodule

// File: rtl/axis_seq_checker.sv
// AXI-Stream sink that checks an incrementing data sequence, with optional
// pseudo-random backpressure, and reports beat/error counts.
import axis_tb_pkg::*;

module axis_seq_checker #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter logic [15:0] LFSR_SEED  = LFSR_DEFAULT_SEED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_beats,
  input  logic [DATA_WIDTH-1:0] first_value,
  input  logic                  stall_en,
  input  logic                  S_AXIS_TVALID,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  output logic                  S_AXIS_TREADY,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  first_err_idx
);

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] expected;
  logic [CNT_WIDTH-1:0]  num_lat;
  logic                  lfsr_bit;
  logic                  start_ok;
  logic                  hs;
  logic                  last_beat;

  assign start_ok  = start && (state != ST_RUN);
  assign hs        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign last_beat = (beat_count == (num_lat - CNT_ONE));

  lfsr16 #(
    .RESET_VAL (LFSR_SEED),
    .Q_BITS    (1)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .seed  (LFSR_SEED),
    .en    (state == ST_RUN),
    .q     (lfsr_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    S_AXIS_TREADY = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    pass          = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        pass = (state == ST_DONE) && (err_count == '0);
        if (start) begin
          state_nxt = (num_beats != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        busy          = 1'b1;
        S_AXIS_TREADY = stall_en ? lfsr_bit : 1'b1;
        if (hs && last_beat) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected      <= '0;
      num_lat       <= '0;
      beat_count    <= '0;
      err_count     <= '0;
      first_err_idx <= '1;
    end else if (start_ok) begin
      expected      <= first_value;
      num_lat       <= num_beats;
      beat_count    <= '0;
      err_count     <= '0;
      first_err_idx <= '1;
    end else if ((state == ST_RUN) && hs) begin
      beat_count <= beat_count + CNT_ONE;
      expected   <= expected + DATA_ONE;
      if (S_AXIS_TDATA != expected) begin
        if (err_count != '1) begin
          err_count <= err_count + CNT_ONE;
        end
        // err_count only ever grows within a run, so zero marks the first miss
        if (err_count == '0) begin
          first_err_idx <= beat_count;
        end
      end
    end
  end

endmodule
